spmv_result_writer: RTL and testbench
=====================================

SPMV_RESULT_WRITER -- requirements
Module: spmv_result_writer

Interface
REQ-001 Parameter DATA_W, default 16, the width of one result lane.
REQ-002 Parameter ADDR_W, default 10, the result-BRAM word address width.
REQ-003 Parameter MAX_WORDS, default 1024, the maximum number of BRAM words per run (2048 beats, packed two beats per word).
REQ-004 Port list:
- clk  in  1  clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that arms a new run.
- in_valid  in  1  result beat valid; driven by the compute-side output strobe.
- in_last  in  1  qualifies the final beat; sampled only when in_valid=1.
- lane0  in  DATA_W  result of compute unit 0 (signed).
- lane1  in  DATA_W  result of compute unit 1 (signed).
- bram_en  out  1  result-BRAM enable.
- bram_we  out  1  result-BRAM write enable.
- bram_addr  out  ADDR_W  result-BRAM word address.
- bram_din  out  4*DATA_W  packed word {b1.lane1, b1.lane0, b0.lane1, b0.lane0}.
- busy  out  1  high while state is COLLECT or FLUSH.
- done  out  1  level signal; high in DONE until the next start.
- overflow  out  1  sticky error flag.
- word_count  out  ADDR_W+1  number of words written in the current run.

Function
REQ-005 The block SHALL implement states IDLE, COLLECT, FLUSH and DONE.
REQ-006 Transitions:
- IDLE -> COLLECT on start.
- COLLECT -> FLUSH on an accepted beat with in_last=1.
- FLUSH -> DONE after exactly one cycle.
- DONE -> COLLECT on start.
REQ-007 start in any state SHALL clear word_count, bram_addr, the pack register, overflow and done, and enter COLLECT on the next cycle; a partial word pending at that moment is discarded.
REQ-008 A beat SHALL be accepted only in COLLECT with in_valid=1; in_valid in IDLE, FLUSH or DONE is ignored.
REQ-009 Packing: the first accepted beat of each pair is held in the pack register; the second beat produces one BRAM write.
REQ-010 Write timing: bram_en=bram_we=1 for exactly the one cycle after the completing beat (1-cycle latency), with bram_addr equal to the current word index.
REQ-011 bram_addr SHALL increment by 1 after each write and SHALL NOT wrap.
REQ-012 in_last on the first beat of a pair SHALL cause FLUSH to write that half-word with the upper 2*DATA_W bits zero; in_last on the second beat writes normally and FLUSH issues no write.
REQ-013 A completing beat arriving when word_count == MAX_WORDS SHALL:
- suppress the write,
- set overflow, which stays set until rst or start,
- leave bram_addr and word_count unchanged.
REQ-014 When no write occurs, bram_en=bram_we=0 and bram_din holds its last value.
REQ-015 word_count SHALL equal the number of writes issued, including the FLUSH write.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL:
- enter IDLE,
- clear all outputs to zero: bram_en, bram_we, bram_addr, bram_din, busy, done, overflow, word_count,
- clear the pack register.
REQ-017 rst mid-run SHALL abort without issuing any further write; rst has priority over start.

Configuration
REQ-018 Macro SPMV_RESULT_RELU_EN:
- When defined, each lane SHALL be clamped to 0 if negative (two's complement MSB set) before packing.
- When undefined, lanes SHALL pass unmodified.
- Write timing SHALL be identical in both builds.

Structure
REQ-019 A shared package spmv_pkg SHALL hold:
- the state encoding constants,
- default DATA_W, ADDR_W and MAX_WORDS,
- the result-count constant 2048.
REQ-020 The optional ReLU SHALL be a sub-module spmv_relu_clamp, instantiated once per lane; all other logic SHALL stay in one module.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Start, then 4 beats with lane0=beat index and lane1=beat index+100, last beat flagged -> 2 writes: addr0 = {101,1,100,0}, addr1 = {103,3,102,2}; done=1; word_count=2.
- 3 beats with the last flagged -> addr1 = {0,0,102,2} written in the FLUSH cycle; word_count=2.
- MAX_WORDS=4 with 10 beats -> 4 writes, overflow=1, no write to addr 4, bram_addr=4.
- start after 3 beats (pending half-word) -> no write of the pending data; the next 2 beats write to addr 0.
- rst asserted the same cycle as a completing beat -> no write; all outputs 0; IDLE.
- With SPMV_RESULT_RELU_EN: lane0=-5 (0xFFFB) and lane1=7 -> packed lanes 0x0000 and 0x0007; without the macro -> 0xFFFB and 0x0007.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV result path: FSM state encoding and default sizes.
package spmv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 10;
  localparam int MAX_WORDS_DEF = 1024;
  localparam int RESULT_COUNT  = 2048;

endpackage

// File: rtl/spmv_relu_clamp.sv
// Per-lane result conditioning: clamps negative lanes to zero when SPMV_RESULT_RELU_EN
// is defined, otherwise passes the lane through untouched.
module spmv_relu_clamp
  import spmv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] in_lane,
  output logic [DATA_W-1:0] out_lane
);

`ifdef SPMV_RESULT_RELU_EN
  assign out_lane = in_lane[DATA_W-1] ? {DATA_W{1'b0}} : in_lane;
`else
  assign out_lane = in_lane;
`endif

endmodule

// File: rtl/spmv_result_writer.sv
// Packs pairs of two-lane result beats into 4-lane BRAM words and writes them out.
// Optional lane ReLU is selected by SPMV_RESULT_RELU_EN (see spmv_relu_clamp).
module spmv_result_writer
  import spmv_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [DATA_W-1:0]   lane0,
  input  logic [DATA_W-1:0]   lane1,
  output logic                bram_en,
  output logic                bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [4*DATA_W-1:0] bram_din,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W:0]     word_count
);

  localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

  state_e                r_state;
  logic                  r_half;
  logic [2*DATA_W-1:0]   r_pack;
  logic                  r_bram_en;
  logic [ADDR_W-1:0]     r_bram_addr;
  logic [4*DATA_W-1:0]   r_bram_din;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
  logic [ADDR_W:0]       r_word_count;

  logic [DATA_W-1:0]     w_lane0;
  logic [DATA_W-1:0]     w_lane1;
  logic [2*DATA_W-1:0]   w_beat;
  logic [4*DATA_W-1:0]   w_word;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_room;

  spmv_relu_clamp #(.DATA_W(DATA_W)) u_relu0 (.in_lane(lane0), .out_lane(w_lane0));
  spmv_relu_clamp #(.DATA_W(DATA_W)) u_relu1 (.in_lane(lane1), .out_lane(w_lane1));

  // A beat completes a word either as the second of a pair or as a lone last beat.
  assign w_beat     = {w_lane1, w_lane0};
  assign w_accept   = (r_state == ST_COLLECT) && in_valid;
  assign w_complete = w_accept && (r_half || in_last);
  assign w_word     = r_half ? {w_beat, r_pack} : {{(2*DATA_W){1'b0}}, w_beat};
  assign w_room     = (r_word_count != MAX_CNT);

  // Control FSM with all outputs registered; bram_addr advances after each write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_half       <= 1'b0;
      r_pack       <= {(2*DATA_W){1'b0}};
      r_bram_en    <= 1'b0;
      r_bram_addr  <= {ADDR_W{1'b0}};
      r_bram_din   <= {(4*DATA_W){1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= {(ADDR_W+1){1'b0}};
    end else if (start) begin
      r_state      <= ST_COLLECT;
      r_half       <= 1'b0;
      r_pack       <= {(2*DATA_W){1'b0}};
      r_bram_en    <= 1'b0;
      r_bram_addr  <= {ADDR_W{1'b0}};
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= {(ADDR_W+1){1'b0}};
    end else begin
      r_bram_en <= 1'b0;
      if (r_bram_en && (r_bram_addr != ADDR_TOP)) begin
        r_bram_addr <= r_bram_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (w_accept) begin
        if (r_half || in_last) begin
          r_half <= 1'b0;
        end else begin
          r_half <= 1'b1;
          r_pack <= w_beat;
        end
      end
      if (w_complete) begin
        if (w_room) begin
          r_bram_en    <= 1'b1;
          r_bram_din   <= w_word;
          r_word_count <= r_word_count + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
          r_overflow   <= 1'b1;
        end
      end
      case (r_state)
        ST_COLLECT: begin
          if (w_accept && in_last) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_IDLE, ST_DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bram_en    = r_bram_en;
  assign bram_we    = r_bram_en;
  assign bram_addr  = r_bram_addr;
  assign bram_din   = r_bram_din;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_spmv_result_writer.sv
// Directed bench for spmv_result_writer: transaction-level model checked every cycle,
// plus literal expectations on the words written in each scenario.
module tb_spmv_result_writer;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [DW-1:0]   lane0 = '0;
  logic [DW-1:0]   lane1 = '0;
  logic            bram_en, bram_we, busy, done, overflow;
  logic [AW-1:0]   bram_addr;
  logic [4*DW-1:0] bram_din;
  logic [AW:0]     word_count;

  spmv_result_writer #(.DATA_W(DW), .ADDR_W(AW), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .lane0(lane0), .lane1(lane1), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .busy(busy), .done(done),
    .overflow(overflow), .word_count(word_count)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: run phase flags, pending half-word, words written, last written word.
  bit              m_collect, m_flush, m_have, m_wr, m_busy, m_done, m_ovf;
  int              m_words;
  logic [2*DW-1:0] m_pend;
  logic [4*DW-1:0] m_din;

  logic [4*DW-1:0] cap [0:15];
  int              wr_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef SPMV_RESULT_RELU_EN
    if ($signed(v) < 0) return '0;
    return v;
`else
    return v;
`endif
  endfunction

  task automatic model_step();
    logic [2*DW-1:0] beat;
    m_wr = 1'b0;
    if (rst) begin
      m_collect = 0; m_flush = 0; m_have = 0; m_busy = 0; m_done = 0; m_ovf = 0;
      m_words = 0; m_pend = '0; m_din = '0;
    end else if (start) begin
      m_collect = 1; m_flush = 0; m_have = 0; m_busy = 1; m_done = 0; m_ovf = 0;
      m_words = 0;
    end else if (m_collect && in_valid) begin
      beat = {relu(lane1), relu(lane0)};
      if (m_have || in_last) begin
        if (m_words < MW) begin
          m_wr = 1'b1;
          m_din = m_have ? {beat, m_pend} : {32'h0, beat};
          m_words++;
        end else begin
          m_ovf = 1'b1;
        end
        m_have = 1'b0;
      end else begin
        m_pend = beat;
        m_have = 1'b1;
      end
      if (in_last) begin
        m_collect = 0;
        m_flush = 1;
      end
    end else if (m_flush) begin
      m_flush = 0; m_busy = 0; m_done = 1;
    end
  endtask

  // Per-cycle comparison against the model, and capture of every written word.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bram_en", 64'(bram_en), 64'(m_wr));
      chk("bram_we", 64'(bram_we), 64'(m_wr));
      chk("bram_addr", 64'(bram_addr), 64'(m_wr ? m_words - 1 : m_words));
      chk("bram_din", bram_din, m_din);
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("word_count", 64'(word_count), 64'(m_words));
      if (bram_en === 1'b1) begin
        wr_cnt++;
        if (bram_addr < 16) cap[bram_addr] = bram_din;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input bit l, input int a, input int b);
    in_valid = v;
    in_last  = l;
    lane0    = a[DW-1:0];
    lane1    = b[DW-1:0];
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    for (int k = 0; k < 16; k++) cap[k] = 64'hDEAD_DEAD_DEAD_DEAD;
    wr_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [63:0] exp_relu;

  initial begin
    wr_cnt = 0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset bram_en", 64'(bram_en), 64'd0);
    chk("reset word_count", 64'(word_count), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 5, 5);
    tick();
    chk("idle ignores beats", 64'(wr_cnt), 64'd0);

    // Four beats, last flagged on the second of the second pair.
    do_start();
    for (int i = 0; i < 4; i++) drive(1'b1, i == 3, i, i + 100);
    repeat (3) tick();
    chk("s1 addr0", cap[0], 64'h0065_0001_0064_0000);
    chk("s1 addr1", cap[1], 64'h0067_0003_0066_0002);
    chk("s1 done", 64'(done), 64'd1);
    chk("s1 word_count", 64'(word_count), 64'd2);
    chk("s1 writes", 64'(wr_cnt), 64'd2);
    drive(1'b1, 1'b1, 9, 9);
    tick();
    chk("s1 done ignores beats", 64'(wr_cnt), 64'd2);

    // Three beats: last beat is a lone half-word flushed with zero upper lanes.
    do_start();
    for (int i = 0; i < 3; i++) drive(1'b1, i == 2, i, i + 100);
    repeat (3) tick();
    chk("s2 addr0", cap[0], 64'h0065_0001_0064_0000);
    chk("s2 addr1", cap[1], 64'h0000_0000_0066_0002);
    chk("s2 word_count", 64'(word_count), 64'd2);

    // Ten beats against a 4-word limit.
    do_start();
    for (int i = 0; i < 10; i++) drive(1'b1, i == 9, i, i + 100);
    repeat (3) tick();
    chk("s3 writes", 64'(wr_cnt), 64'd4);
    chk("s3 addr3", cap[3], 64'h006B_0007_006A_0006);
    chk("s3 no addr4", cap[4], 64'hDEAD_DEAD_DEAD_DEAD);
    chk("s3 overflow", 64'(overflow), 64'd1);
    chk("s3 bram_addr", 64'(bram_addr), 64'd4);
    chk("s3 word_count", 64'(word_count), 64'd4);

    // Restart with a pending half-word; the pending beat must be dropped.
    do_start();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, i, i + 100);
    do_start();
    drive(1'b1, 1'b0, 16'h11, 16'h22);
    drive(1'b1, 1'b1, 16'h33, 16'h44);
    repeat (3) tick();
    chk("s4 writes", 64'(wr_cnt), 64'd1);
    chk("s4 addr0", cap[0], 64'h0044_0033_0022_0011);
    chk("s4 overflow cleared", 64'(overflow), 64'd0);

    // Reset coinciding with a completing beat.
    do_start();
    drive(1'b1, 1'b0, 1, 2);
    rst = 1'b1;
    drive(1'b1, 1'b0, 3, 4);
    rst = 1'b0;
    chk("s5 bram_en", 64'(bram_en), 64'd0);
    chk("s5 bram_din", bram_din, 64'd0);
    chk("s5 busy", 64'(busy), 64'd0);
    chk("s5 word_count", 64'(word_count), 64'd0);
    drive(1'b1, 1'b1, 5, 6);
    tick();
    chk("s5 writes", 64'(wr_cnt), 64'd0);

    // Negative lane through the optional clamp.
`ifdef SPMV_RESULT_RELU_EN
    exp_relu = 64'h0000_0000_0007_0000;
`else
    exp_relu = 64'h0000_0000_0007_FFFB;
`endif
    do_start();
    drive(1'b1, 1'b1, -5, 7);
    repeat (3) tick();
    chk("s6 relu word", cap[0], exp_relu);
    chk("s6 writes", 64'(wr_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
